// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one sram-like memory port between the instruction
// fetch requester (inst_*) and the data requester (data_*).
//   - inst_*/data_* : request side, req held until the matching *_addr_ok
//   - *_addr_ok     : request accepted this cycle
//   - *_data_ok     : response for that requester this cycle, rdata = mem_rdata
//   - mem_*         : downstream port, muxed from the granted side
// Data wins arbitration unless fetch has waited STARVE_LIM data grants.
// Outstanding requests are tracked in a 1-bit owner FIFO so in-order
// downstream responses are routed back to the requester that issued them.
module mem_req_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int STARVE_LIM  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] FULL = CW'(OUTSTANDING);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIM);

    typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

    state_t        state, state_nx;
    logic          gnt_i, gnt_d;
    logic          accept, resp_vld, head;
    logic [CW-1:0] cnt;
    logic [PW-1:0] wptr, rptr;
    logic [SW-1:0] starve;
    logic          owner_q [OUTSTANDING];

    // Grant selection and hold tracking. Once a request is presented and
    // not taken, the grant is frozen until downstream accepts it.
    always_comb begin
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        state_nx = state;
        case (state)
            IDLE: begin
                if (cnt < FULL) begin
                    if (inst_req && (starve == SLIM || !data_req)) gnt_i = 1'b1;
                    else if (data_req)                             gnt_d = 1'b1;
                end
                if (gnt_i && !mem_addr_ok) state_nx = HOLD_I;
                if (gnt_d && !mem_addr_ok) state_nx = HOLD_D;
            end
            // A requester withdrawing a held request is a protocol error;
            // releasing the hold keeps the port from locking up.
            HOLD_I: begin
                gnt_i = 1'b1;
                if (mem_addr_ok || !inst_req) state_nx = IDLE;
            end
            HOLD_D: begin
                gnt_d = 1'b1;
                if (mem_addr_ok || !data_req) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_req   = ~reset & ((gnt_i & inst_req) | (gnt_d & data_req));
    assign mem_wr    = gnt_i ? inst_wr    : data_wr;
    assign mem_size  = gnt_i ? inst_size  : data_size;
    assign mem_addr  = gnt_i ? inst_addr  : data_addr;
    assign mem_wstrb = gnt_i ? inst_wstrb : data_wstrb;
    assign mem_wdata = gnt_i ? inst_wdata : data_wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & gnt_i;
    assign data_addr_ok = accept & gnt_d;

    // A response with nothing outstanding is dropped: no pop, no data_ok.
    assign head         = owner_q[rptr];
    assign resp_vld     = ~reset & mem_data_ok & (cnt != '0);
    assign inst_data_ok = resp_vld & ~head;
    assign data_data_ok = resp_vld & head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            wptr   <= '0;
            rptr   <= '0;
            starve <= '0;
        end else begin
            state <= state_nx;
            // OUTSTANDING is a power of 2, so pointers wrap naturally.
            if (accept)   wptr <= wptr + 1'b1;
            if (resp_vld) rptr <= rptr + 1'b1;
            case ({accept, resp_vld})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (!inst_req || inst_addr_ok)         starve <= '0;
            else if (data_addr_ok && starve != SLIM) starve <= starve + 1'b1;
        end
    end

    // Owner storage needs no reset: entries are only read below cnt.
    always_ff @(posedge clk) begin
        if (accept) owner_q[wptr] <= gnt_d;
    end
endmodule
